// File: rtl/axi4_lite_pkg.sv
// Shared types and address helpers for the AXI4-Lite register slave.
// AXI_LITE_WSTRB_EN selects byte-strobe support in the slave.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    function automatic logic [31:0] addr_to_idx(
        input logic [63:0] addr,
        input int unsigned lsb,
        input int unsigned iw
    );
        return 32'((addr >> lsb) & ((64'd1 << iw) - 64'd1));
    endfunction

    // Any address bit above the index field makes the access invalid.
    function automatic logic addr_in_range(
        input logic [63:0] addr,
        input int unsigned lsb,
        input int unsigned iw
    );
        return (addr >> (lsb + iw)) == 64'd0;
    endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// Register array: one byte-enabled write port, one combinational read port.
// Every register reloads RESET_VAL on reset.
module axi4_lite_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned IDX_W      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [IDX_W-1:0]        ridx,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (we) begin
            for (int b = 0; b < int'(DATA_WIDTH / 8); b++) begin
                if (wbe[b]) begin
                    regs[widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = regs[ridx];

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers with OKAY/SLVERR responses.
// Define AXI_LITE_WSTRB_EN to add the WSTRB port and per-byte writes.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
`ifdef AXI_LITE_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
`endif
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int unsigned NB  = DATA_WIDTH / 8;
    localparam int unsigned LSB = $clog2(NB);
    localparam int unsigned IW  = $clog2(NUM_REGS);

    wr_state_t wstate;
    rd_state_t rstate;

    logic                  aw_done, w_done;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdat;
    logic [NB-1:0]         wbe;
    logic [IW-1:0]         widx, ridx;
    logic [DATA_WIDTH-1:0] rf_rdata;
    logic aw_hs, w_hs, aw_ok, w_ok, commit, w_inr, we;
    logic ar_hs, ar_inr;

    assign aw_hs  = AWVALID && AWREADY;
    assign w_hs   = WVALID && WREADY;
    assign aw_ok  = aw_done || aw_hs;
    assign w_ok   = w_done || w_hs;
    assign commit = (wstate == W_IDLE) && aw_ok && w_ok;

    // Halves that arrived earlier come from the capture registers.
    assign waddr = aw_done ? awaddr_q : AWADDR;
    assign wdat  = w_done ? wdata_q : WDATA;
    assign w_inr = addr_in_range(64'(waddr), LSB, IW);
    assign widx  = IW'(addr_to_idx(64'(waddr), LSB, IW));
    assign we    = commit && w_inr;

`ifdef AXI_LITE_WSTRB_EN
    logic [NB-1:0] wstrb_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstrb_q <= '0;
        end else if (wstate == W_IDLE && w_hs) begin
            wstrb_q <= WSTRB;
        end
    end

    assign wbe = w_done ? wstrb_q : WSTRB;
`else
    assign wbe = '1;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate   <= W_IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BRESP    <= OKAY;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (commit) begin
                        wstate  <= W_RESP;
                        BVALID  <= 1'b1;
                        BRESP   <= w_inr ? OKAY : SLVERR;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        if (aw_hs) begin
                            aw_done  <= 1'b1;
                            awaddr_q <= AWADDR;
                        end
                        if (w_hs) begin
                            w_done  <= 1'b1;
                            wdata_q <= WDATA;
                        end
                        AWREADY <= !aw_ok;
                        WREADY  <= !w_ok;
                    end
                end
                W_RESP: begin
                    if (BVALID && BREADY) begin
                        wstate  <= W_IDLE;
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    assign ar_hs  = ARVALID && ARREADY;
    assign ar_inr = addr_in_range(64'(ARADDR), LSB, IW);
    assign ridx   = IW'(addr_to_idx(64'(ARADDR), LSB, IW));

    // Read data is sampled before any same-edge write lands in the array.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate  <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= OKAY;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate  <= R_DATA;
                        ARREADY <= 1'b0;
                        RVALID  <= 1'b1;
                        RDATA   <= ar_inr ? rf_rdata : '0;
                        RRESP   <= ar_inr ? OKAY : SLVERR;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RVALID && RREADY) begin
                        rstate  <= R_IDLE;
                        RVALID  <= 1'b0;
                        ARREADY <= 1'b1;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    axi4_lite_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IW),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk  (ACLK),
        .rst  (ARESET),
        .we   (we),
        .widx (widx),
        .wdata(wdat),
        .wbe  (wbe),
        .ridx (ridx),
        .rdata(rf_rdata)
    );

endmodule
